audio_sample_reader: RTL and testbench

AUDIO_SAMPLE_READER -- requirements
Module: audio_sample_reader

---
 rtl/audio_sample_reader.sv | 136 +++++++++++++
 tb/tb_audio_sample_reader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_reader.sv
// Streams 8-bit audio samples out of 32-bit flash words (two 16-bit samples per word),
// one sample per accepted sample tick, forward or backward through the clip with restart support.
module audio_sample_reader #(
  parameter logic [22:0] LAST_ADDR = 23'h7FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_tick,
  input  logic        play,
  input  logic        direction,
  input  logic        restart,
  output logic [22:0] flash_address,
  output logic        flash_read,
  input  logic        flash_waitrequest,
  input  logic [31:0] flash_readdata,
  input  logic        flash_readdatavalid,
  output logic [7:0]  audio_data,
  output logic        audio_valid
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT_DATA, WAIT_TICK0, OUT0, WAIT_TICK1, OUT1, ADV
  } state_t;

  state_t      state, state_nxt;
  logic [22:0] addr_nxt, start_addr, step_addr;
  logic [7:0]  word_lo, word_hi, word_lo_nxt, word_hi_nxt;
  logic        word_dir, word_dir_nxt;
  logic [7:0]  data_nxt;
  logic        pending, pending_nxt;
  logic        apply;

  // Only the upper byte of each 16-bit sample reaches the output.
  logic unused_readdata;
  assign unused_readdata = ^{flash_readdata[23:16], flash_readdata[7:0]};

  assign start_addr = direction ? LAST_ADDR : 23'd0;

  always_comb begin
    if (direction) step_addr = (flash_address == 23'd0) ? LAST_ADDR : flash_address - 23'd1;
    else           step_addr = (flash_address == LAST_ADDR) ? 23'd0 : flash_address + 23'd1;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    state_nxt    = state;
    addr_nxt     = flash_address;
    word_lo_nxt  = word_lo;
    word_hi_nxt  = word_hi;
    word_dir_nxt = word_dir;
    data_nxt     = audio_data;
    flash_read   = 1'b0;
    audio_valid  = 1'b0;
    apply        = 1'b0;

    case (state)
      IDLE: begin
        if (play) begin
          apply     = pending;
          state_nxt = REQ;
        end
      end
      REQ: begin
        flash_read = 1'b1;
        if (!flash_waitrequest) state_nxt = WAIT_DATA;
      end
      WAIT_DATA: begin
        // A pending restart waits here so the accepted read is always drained.
        if (flash_readdatavalid) begin
          word_lo_nxt  = flash_readdata[15:8];
          word_hi_nxt  = flash_readdata[31:24];
          word_dir_nxt = direction;
          state_nxt    = WAIT_TICK0;
        end
      end
      WAIT_TICK0: begin
        if (pending) begin
          apply     = 1'b1;
          state_nxt = REQ;
        end else if (sample_tick && play) begin
          data_nxt  = word_dir ? word_hi : word_lo;
          state_nxt = OUT0;
        end
      end
      OUT0: begin
        audio_valid = 1'b1;
        state_nxt   = WAIT_TICK1;
      end
      WAIT_TICK1: begin
        if (pending) begin
          apply     = 1'b1;
          state_nxt = REQ;
        end else if (sample_tick && play) begin
          data_nxt  = word_dir ? word_lo : word_hi;
          state_nxt = OUT1;
        end
      end
      OUT1: begin
        audio_valid = 1'b1;
        state_nxt   = ADV;
      end
      ADV: begin
        state_nxt = REQ;
        if (pending) apply = 1'b1;
        else         addr_nxt = step_addr;
      end
      default: state_nxt = IDLE;
    endcase

    if (apply) addr_nxt = start_addr;
    // A restart arriving in the same cycle as an applied one is absorbed by it.
    pending_nxt = apply ? 1'b0 : (pending | restart);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state         <= IDLE;
      flash_address <= 23'd0;
      word_lo       <= 8'h00;
      word_hi       <= 8'h00;
      word_dir      <= 1'b0;
      audio_data    <= 8'h00;
      pending       <= 1'b0;
    end else begin
      state         <= state_nxt;
      flash_address <= addr_nxt;
      word_lo       <= word_lo_nxt;
      word_hi       <= word_hi_nxt;
      word_dir      <= word_dir_nxt;
      audio_data    <= data_nxt;
      pending       <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_audio_sample_reader.sv
// Self-checking bench for audio_sample_reader: a sample-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized playback against a flash responder.
module tb_audio_sample_reader;

  localparam logic [22:0] LAST = 23'h7FFFF;

  logic        clk = 1'b0;
  logic        reset, sample_tick, play, direction, restart;
  logic        flash_waitrequest, flash_readdatavalid;
  logic [31:0] flash_readdata;
  logic [22:0] flash_address;
  logic        flash_read;
  logic [7:0]  audio_data;
  logic        audio_valid;

  always #10 clk = ~clk;

  audio_sample_reader #(.LAST_ADDR(LAST)) dut (
    .clk                 (clk),
    .reset               (reset),
    .sample_tick         (sample_tick),
    .play                (play),
    .direction           (direction),
    .restart             (restart),
    .flash_address       (flash_address),
    .flash_read          (flash_read),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
    .audio_data          (audio_data),
    .audio_valid         (audio_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 25) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the player is either idle, requesting, awaiting data, showing a sample,
  // or otherwise holding a queue of unplayed samples (empty queue = about to fetch the next word).
  bit         m_idle = 1'b1, m_req = 1'b0, m_wait = 1'b0, m_out = 1'b0, m_pend = 1'b0;
  logic [22:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  logic [7:0]  m_halves[$];

  task automatic model_step();
    bit active, apply;
    int n;
    if (!reset) begin
      m_idle = 1'b1; m_req = 1'b0; m_wait = 1'b0; m_out = 1'b0; m_pend = 1'b0;
      m_addr = '0; m_data = '0; m_halves.delete();
      return;
    end
    n      = int'(LAST) + 1;
    active = !(m_idle || m_req || m_wait || m_out);
    apply  = m_pend && ((m_idle && play) || active);
    m_pend = apply ? 1'b0 : (m_pend || restart);
    if (m_idle) begin
      if (play) begin m_idle = 1'b0; m_req = 1'b1; end
    end else if (m_req) begin
      if (!flash_waitrequest) begin m_req = 1'b0; m_wait = 1'b1; end
    end else if (m_wait) begin
      if (flash_readdatavalid) begin
        m_wait = 1'b0;
        if (direction) m_halves = '{flash_readdata[31:24], flash_readdata[15:8]};
        else           m_halves = '{flash_readdata[15:8], flash_readdata[31:24]};
      end
    end else if (m_out) begin
      m_out = 1'b0;
    end else if (apply) begin
      m_halves.delete();
      m_req = 1'b1;
    end else if (m_halves.size() != 0) begin
      if (sample_tick && play) begin m_data = m_halves.pop_front(); m_out = 1'b1; end
    end else begin
      m_addr = 23'((int'(m_addr) + (direction ? n - 1 : 1)) % n);
      m_req  = 1'b1;
    end
    if (apply) m_addr = direction ? LAST : 23'd0;
  endtask

  // Flash responder: random stalls and latency, optional fixed data and stray readdatavalid pulses.
  bit          manual = 1'b0, spurious = 1'b0, force_word = 1'b0, outstanding = 1'b0;
  logic [31:0] fixed_word = 32'hA1B2C3D4;
  logic [22:0] out_addr;
  int          wr_pct = 0, lat_min = 0, lat_max = 0, wr_force = 0, accepts = 0, lat_cnt = 0;

  function automatic logic [31:0] word_at(input logic [22:0] a);
    return force_word ? fixed_word : ((32'h9E3779B9 * {9'd0, a}) ^ 32'h5A5A1234);
  endfunction

  task automatic respond_flash();
    if (manual) return;
    flash_readdatavalid = 1'b0;
    flash_readdata      = $urandom();
    if (outstanding) begin
      if (lat_cnt == 0) begin
        flash_readdatavalid = 1'b1;
        flash_readdata      = word_at(out_addr);
        outstanding         = 1'b0;
      end else lat_cnt--;
    end else if (spurious && $urandom_range(7) == 0) flash_readdatavalid = 1'b1;
    if (outstanding) flash_waitrequest = 1'b1;
    else if (flash_read && wr_force > 0) begin flash_waitrequest = 1'b1; wr_force--; end
    else flash_waitrequest = (int'($urandom_range(99)) < wr_pct);
    if (flash_read && !flash_waitrequest) begin
      outstanding = 1'b1;
      out_addr    = flash_address;
      lat_cnt     = int'($urandom_range(lat_max, lat_min));
      accepts++;
    end
  endtask

  bit          cmp_en = 1'b0;
  logic        s_read, s_valid;
  logic [7:0]  s_data;
  logic [22:0] s_addr;

  task automatic step();
    @(negedge clk);
    s_read = flash_read; s_valid = audio_valid; s_data = audio_data; s_addr = flash_address;
    if (cmp_en) begin
      check("flash_read", s_read, m_req);
      check("flash_address", s_addr, m_addr);
      check("audio_valid", s_valid, m_out);
      check("audio_data", s_data, m_data);
    end
    respond_flash();
    @(posedge clk);
    model_step();
    #1;
    sample_tick = 1'b0;
    restart     = 1'b0;
  endtask

  task automatic wait_read(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin step(); seen = s_read; end
    check({name, "_seen"}, seen, 1);
  endtask

  task automatic tick_until_valid(input string name, output logic [7:0] d);
    bit seen = 1'b0;
    d = 8'hxx;
    for (int i = 0; i < 40 && !seen; i++) begin
      sample_tick = 1'b1;
      step();
      if (s_valid) begin seen = 1'b1; d = s_data; end
    end
    check({name, "_seen"}, seen, 1);
  endtask

  task automatic restart_to(input string name, input logic [22:0] exp_addr);
    bit seen = 1'b0;
    int outs = 0;
    restart = 1'b1;
    for (int i = 0; i < 30 && !seen; i++) begin
      sample_tick = 1'b1;
      step();
      if (s_valid) outs++;
      if (s_read) seen = 1'b1;
    end
    check({name, "_seen"}, seen, 1);
    check({name, "_no_output"}, outs, 0);
    check({name, "_addr"}, s_addr, exp_addr);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int n, a0;
    bit found;

    reset = 1'b0; play = 1'b0; direction = 1'b0; restart = 1'b0; sample_tick = 1'b0;
    flash_waitrequest = 1'b0; flash_readdatavalid = 1'b0; flash_readdata = '0;

    // Reset state
    step();
    cmp_en = 1'b1;
    step();
    check("rst_read", s_read, 0);
    check("rst_valid", s_valid, 0);
    check("rst_data", s_data, 8'h00);
    check("rst_addr", s_addr, 0);

    // Forward playback of one word, exact one-cycle latency and data hold
    force_word = 1'b1; fixed_word = 32'hA1B2C3D4; wr_pct = 0; lat_min = 0; lat_max = 0;
    reset = 1'b1; play = 1'b1; direction = 1'b0;
    wait_read("t1_req");
    check("t1_addr", s_addr, 0);
    repeat (4) step();
    sample_tick = 1'b1; step();
    step();
    check("t1_valid0", s_valid, 1);
    check("t1_data0", s_data, 8'hC3);
    step();
    check("t1_pulse", s_valid, 0);
    check("t1_hold", s_data, 8'hC3);
    sample_tick = 1'b1; step();
    step();
    check("t1_valid1", s_valid, 1);
    check("t1_data1", s_data, 8'hA1);

    // Request stalled by waitrequest for five cycles
    wr_force = 5;
    wait_read("t2_req");
    check("t2_addr0", s_addr, 1);
    a0 = accepts; n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!s_read) break;
      n++;
      check("t2_addr", s_addr, 1);
      check("t2_novalid", s_valid, 0);
    end
    check("t2_read_cycles", n, 6);
    check("t2_accepts", accepts - a0, 1);

    // Backward from address 0 wraps to LAST; forward from LAST wraps to 0
    reset = 1'b0; step();
    reset = 1'b1; direction = 1'b1;
    wait_read("t3_req");
    check("t3_addr", s_addr, 0);
    tick_until_valid("t3_first", d);  check("t3_first", d, 8'hA1);
    tick_until_valid("t3_second", d); check("t3_second", d, 8'hC3);
    wait_read("t3_wrap");
    check("t3_wrap_addr", s_addr, 23'h7FFFF);
    direction = 1'b0;

    // Pause in the middle of a word
    tick_until_valid("t4_first", d); check("t4_first", d, 8'hC3);
    play = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample_tick = 1'b1;
      step();
      check("t4_pause_valid", s_valid, 0);
      check("t4_pause_data", s_data, 8'hC3);
      check("t4_pause_read", s_read, 0);
    end
    play = 1'b1;
    sample_tick = 1'b1; step();
    step();
    check("t4_resume_valid", s_valid, 1);
    check("t4_resume_data", s_data, 8'hA1);
    wait_read("t4_wrap");
    check("t4_wrap_addr", s_addr, 0);

    // Restart while a read is in flight
    lat_min = 3; lat_max = 3; found = 1'b0;
    for (int i = 0; i < 6000 && !found; i++) begin
      sample_tick = 1'b1;
      step();
      if (s_read && s_addr == 23'h100) found = 1'b1;
    end
    check("t5_reach_0x100", found, 1);
    restart_to("t5_fwd", 23'd0);
    direction = 1'b1;
    restart_to("t5_bwd", 23'h7FFFF);

    // Reset during WAIT_DATA, then a late readdatavalid
    manual = 1'b1; outstanding = 1'b0;
    flash_waitrequest = 1'b0; flash_readdatavalid = 1'b0;
    play = 1'b0; reset = 1'b0;
    step();
    reset = 1'b1; flash_readdatavalid = 1'b1; flash_readdata = 32'hA1B2C3D4;
    step();
    flash_readdatavalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t6_read", s_read, 0);
      check("t6_valid", s_valid, 0);
      check("t6_data", s_data, 8'h00);
      check("t6_addr", s_addr, 0);
    end
    manual = 1'b0;

    // Randomized playback
    force_word = 1'b0; spurious = 1'b1; wr_pct = 30; lat_min = 0; lat_max = 4;
    for (int i = 0; i < 4000; i++) begin
      play        = ($urandom_range(99) < 85);
      sample_tick = ($urandom_range(99) < 35);
      if ($urandom_range(99) < 4) direction = ~direction;
      restart     = ($urandom_range(99) < 3);
      reset       = !($urandom_range(999) < 3);
      step();
    end
    reset = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
